// File: rtl/reg_scoreboard.sv
// Issue-side GPR scoreboard: counts writes in flight between D-stage issue
// and W-stage retire, and stalls D while a source still has a pending write.
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rs,
    input  logic [AW-1:0]       issue_rt,
    input  logic                issue_use_rs,
    input  logic                issue_use_rt,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_dst,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_a3,
    output logic                stall,
    output logic [NREG-1:0]     busy_mask,
    output logic [AW+CNT_W-1:0] inflight,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    r_pending [NREG];
    logic [AW+CNT_W-1:0] r_inflight;
    logic                r_err;

    logic [CNT_W-1:0] w_pend_rs;
    logic [CNT_W-1:0] w_pend_rt;
    logic [CNT_W-1:0] w_pend_dst;
    logic [CNT_W-1:0] w_pend_wb;
    logic             w_byp;
    logic             w_rs_haz;
    logic             w_rt_haz;
    logic             w_sat_haz;
    logic             w_accept;
    logic             w_inc;
    logic             w_dec;
    logic             w_underflow;
    logic [CNT_W-1:0] w_pend_nxt [NREG];

    assign w_pend_rs  = r_pending[issue_rs];
    assign w_pend_rt  = r_pending[issue_rt];
    assign w_pend_dst = r_pending[issue_dst];
    assign w_pend_wb  = r_pending[wb_a3];

    // A write retiring this cycle is visible to the reader (write-first RF)
    // only when it is the last outstanding write to that register.
    assign w_byp = (WB_BYPASS != 0) && wb_valid;

    assign w_rs_haz = (issue_rs != '0) && (w_pend_rs != '0)
                   && !(w_byp && (wb_a3 == issue_rs)
                        && (w_pend_rs == CNT_ONE));

    assign w_rt_haz = (issue_rt != '0) && (w_pend_rt != '0)
                   && !(w_byp && (wb_a3 == issue_rt)
                        && (w_pend_rt == CNT_ONE));

    assign w_sat_haz = issue_wen && (issue_dst != '0)
                    && (w_pend_dst == CNT_MAX);

    assign stall = issue_valid
                && ((issue_use_rs && w_rs_haz)
                    || (issue_use_rt && w_rt_haz)
                    || w_sat_haz);

    assign w_accept    = issue_valid && !stall;
    assign w_inc       = w_accept && issue_wen && (issue_dst != '0);
    assign w_dec       = wb_valid && (wb_a3 != '0) && (w_pend_wb != '0);
    assign w_underflow = wb_valid && (wb_a3 != '0) && (w_pend_wb == '0);

    always_comb begin
        w_pend_nxt = r_pending;
        for (int i = 1; i < NREG; i++) begin
            if (w_inc && (issue_dst == AW'(i))
                && !(w_dec && (wb_a3 == AW'(i)))) begin
                w_pend_nxt[i] = r_pending[i] + CNT_ONE;
            end else if (w_dec && (wb_a3 == AW'(i))
                         && !(w_inc && (issue_dst == AW'(i)))) begin
                w_pend_nxt[i] = r_pending[i] - CNT_ONE;
            end
        end
        w_pend_nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_pending[i] <= '0;
            end
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_inc && !w_dec) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_inflight <= r_inflight - 1'b1;
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_mask[i] = (r_pending[i] != '0);
        end
    end

    assign inflight      = r_inflight;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Vector-table bench for reg_scoreboard; post-edge expectations go through a queue.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic        issue_wen;
    logic [4:0]  issue_dst;
    logic        wb_valid;
    logic [4:0]  wb_a3;
    logic        stall;
    logic [31:0] busy_mask;
    logic [6:0]  inflight;
    logic        err_underflow;
    logic        stall_nb;
    logic [31:0] busy_nb;
    logic [6:0]  infl_nb;
    logic        err_nb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.WB_BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_wen(issue_wen), .issue_dst(issue_dst),
        .wb_valid(wb_valid), .wb_a3(wb_a3),
        .stall(stall), .busy_mask(busy_mask),
        .inflight(inflight), .err_underflow(err_underflow)
    );

    reg_scoreboard #(.WB_BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_wen(issue_wen), .issue_dst(issue_dst),
        .wb_valid(wb_valid), .wb_a3(wb_a3),
        .stall(stall_nb), .busy_mask(busy_nb),
        .inflight(infl_nb), .err_underflow(err_nb)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        wen;
        logic [4:0]  dst;
        logic        wbv;
        logic [4:0]  a3;
        logic        stl;
        logic [6:0]  infl;
        logic [31:0] busy;
        logic        err;
        logic        chk_nb;
        logic        stl_nb;
    } vec_t;

    typedef struct {
        logic [6:0]  infl;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic wen,
        input logic [4:0] dst, input logic wbv, input logic [4:0] a3,
        input logic stl, input logic [6:0] infl,
        input logic [31:0] busy, input logic err);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
        t.wen = wen; t.dst = dst; t.wbv = wbv; t.a3 = a3;
        t.stl = stl; t.infl = infl; t.busy = busy; t.err = err;
        t.chk_nb = 1'b0; t.stl_nb = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        issue_valid  = t.v;
        issue_rs     = t.rs;
        issue_rt     = t.rt;
        issue_use_rs = t.urs;
        issue_use_rt = t.urt;
        issue_wen    = t.wen;
        issue_dst    = t.dst;
        wb_valid     = t.wbv;
        wb_a3        = t.a3;
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        drive(t);
        #2;
        chk($sformatf("stall[%0d]", idx), 64'(stall), 64'(t.stl));
        if (t.chk_nb)
            chk($sformatf("stall_nb[%0d]", idx), 64'(stall_nb), 64'(t.stl_nb));
        exp_q.push_back('{t.infl, t.busy, t.err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("inflight[%0d]", idx), 64'(inflight), 64'(e.infl));
        chk($sformatf("busy[%0d]", idx), 64'(busy_mask), 64'(e.busy));
        chk($sformatf("err[%0d]", idx), 64'(err_underflow), 64'(e.err));
    endtask

    vec_t idle;
    vec_t h;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //       v  rs rt us ut wn dst wb a3 st in busy        er
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 1, 32'h100, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 1, 10, 0, 0, 1, 1, 32'h100, 0));
        tbl.push_back(mk(1, 8, 0, 1, 0, 1, 10, 1, 8, 0, 1, 32'h400, 0));
        tbl.push_back(mk(1, 0, 10, 0, 1, 1, 3, 0, 0, 1, 1, 32'h400, 0));
        tbl.push_back(mk(1, 0, 10, 0, 1, 1, 3, 1, 10, 0, 1, 32'h8, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 1, 32'h8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 2, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 3, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 1, 3, 32'h200, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 2, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 3, 32'h200, 0));
        tbl.push_back(mk(1, 9, 0, 1, 0, 0, 0, 1, 9, 1, 2, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2, 32'h200, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 2, 32'h200, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 2, 32'h200, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 32'h200, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h20, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 2, 32'h20, 1));
        tbl.push_back(mk(1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 3, 32'hA0, 1));
        tbl.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0, 1, 3, 32'hA0, 1));
        tbl.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 3, 32'hA0, 1));

        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Mid-run async reset with pending[5]=2 and pending[7]=1.
        @(negedge clk);
        issue_valid  = 1'b1;
        issue_use_rs = 1'b1;
        issue_rs     = 5'd5;
        issue_use_rt = 1'b1;
        issue_rt     = 5'd7;
        issue_wen    = 1'b0;
        wb_valid     = 1'b0;
        #1;
        chk("pre_rst_stall", 64'(stall), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", 64'(stall), 64'd0);
        chk("mid_rst_busy", 64'(busy_mask), 64'd0);
        chk("mid_rst_inflight", 64'(inflight), 64'd0);
        chk("mid_rst_err", 64'(err_underflow), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // RAW with and without write-first bypass.
        h = mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 1, 32'h100, 0);
        h.chk_nb = 1'b1; h.stl_nb = 1'b0;
        apply(h, 100);
        h = mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h100, 0);
        h.chk_nb = 1'b1; h.stl_nb = 1'b1;
        apply(h, 101);
        h = mk(1, 8, 0, 1, 0, 0, 0, 1, 8, 0, 0, 32'h0, 0);
        h.chk_nb = 1'b1; h.stl_nb = 1'b1;
        apply(h, 102);
        h = mk(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        h.chk_nb = 1'b1; h.stl_nb = 1'b0;
        apply(h, 103);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
